// File: rtl/cpu_types_pkg.sv
// cpu_types: shared widths and the writeback request record used by the
// execute/writeback slice of the barrel-threaded core.
package cpu_types;

  localparam int XLEN    = 32;
  localparam int THREADS = 4;
  localparam int TID_W   = $clog2(THREADS);
  localparam int PC_W    = 29;

  typedef logic [4:0] rs_addr_t;

  // One pending register-file write: destination, value and owning thread.
  typedef struct packed {
    rs_addr_t              rd_addr;
    logic [XLEN-1:0]       data;
    logic [TID_W-1:0]      thread;
  } wb_req_t;

endpackage

// File: rtl/wb_lsu_fifo.sv
// wb_lsu_fifo: synchronous FIFO of load results waiting for the register-file
// write port. DEPTH must be a power of two so the pointers wrap for free.
module wb_lsu_fifo
  import cpu_types::*;
#(
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  wb_req_t       din_i,
  output wb_req_t       dout_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  wb_req_t       mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Storage array: payload only, so it is written on push and never reset.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  // Occupancy: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i)      count_d = count_q + 1'b1;
    else if (pop_i && !push_i) count_d = count_q - 1'b1;
  end

  // Pointer and count registers; reset empties the queue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/exu_writeback.sv
// exu_writeback: merges ALU results and queued LSU loads onto the single
// register-file write port, holds one PC per hardware thread and pulses
// thread_done when an instruction retires.
// Optional feature macro: WB_PERF_EN adds saturating 32-bit event counters.
module exu_writeback #(
  parameter int  XLEN      = cpu_types::XLEN,
  parameter int  THREADS   = cpu_types::THREADS,
  parameter int  PC_W      = cpu_types::PC_W,
  parameter int  LSU_DEPTH = 4,
  localparam int TID_W     = $clog2(THREADS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_valid,
  input  logic                    alu_rd_en,
  input  logic [4:0]              alu_rd_addr,
  input  logic [XLEN-1:0]         alu_rd_data,
  input  logic [PC_W-1:0]         alu_new_pc,
  input  logic [TID_W-1:0]        alu_thread,
  input  logic                    lsu_valid,
  output logic                    lsu_ready,
  input  logic [4:0]              lsu_rd_addr,
  input  logic [XLEN-1:0]         lsu_rd_data,
  input  logic [TID_W-1:0]        lsu_thread,
  output logic                    rf_we,
  output logic [4:0]              rf_waddr,
  output logic [XLEN-1:0]         rf_wdata,
  output logic [TID_W-1:0]        rf_thread,
  output logic [THREADS*PC_W-1:0] pc_q,
`ifdef WB_PERF_EN
  output logic [31:0]             perf_alu_wr,
  output logic [31:0]             perf_lsu_wr,
  output logic [31:0]             perf_lsu_stall,
`endif
  output logic [THREADS-1:0]      thread_done
);

  import cpu_types::*;

  localparam int CW = $clog2(LSU_DEPTH) + 1;

  wb_req_t          fifo_din;
  wb_req_t          fifo_head;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic [CW:0]      cnt_next;

  logic             alu_wr;
  logic             alu_load_slot;
  logic             alu_retire;
  logic             lsu_wr;

  logic             rf_we_q,     rf_we_d;
  logic [4:0]       rf_waddr_q,  rf_waddr_d;
  logic [XLEN-1:0]  rf_wdata_q,  rf_wdata_d;
  logic [TID_W-1:0] rf_thread_q, rf_thread_d;
  logic [THREADS-1:0] done_q,    done_d;
  logic             lsu_ready_q, lsu_ready_d;
  logic [PC_W-1:0]  pc_tbl_q [THREADS];

  // A load's ALU slot carries rd with rd_en low: the LSU owns that rd and
  // retires the thread later, so the slot itself must not pulse done.
  assign alu_wr        = alu_valid && alu_rd_en && (alu_rd_addr != 5'd0);
  assign alu_load_slot = alu_valid && !alu_rd_en && (alu_rd_addr != 5'd0);
  assign alu_retire    = alu_valid && !alu_load_slot;

  assign fifo_din  = '{rd_addr: lsu_rd_addr, data: lsu_rd_data, thread: lsu_thread};
  assign fifo_push = lsu_valid && lsu_ready_q && !fifo_full;
  assign fifo_pop  = !fifo_empty && !alu_wr;
  assign lsu_wr    = fifo_pop && (fifo_head.rd_addr != 5'd0);

  wb_lsu_fifo #(
    .DEPTH   (LSU_DEPTH)
  ) u_lsu_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (fifo_din),
    .dout_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Ready is registered from next-cycle occupancy so it drops right after
  // the last slot fills and reads 0 while reset is held.
  assign cnt_next    = {1'b0, fifo_count} + {{CW{1'b0}}, fifo_push} - {{CW{1'b0}}, fifo_pop};
  assign lsu_ready_d = (cnt_next < (CW+1)'(LSU_DEPTH));

  // Write-port arbitration: ALU has fixed priority, x0 writes are dropped,
  // and the address/data registers hold their value when nothing writes.
  always_comb begin
    rf_we_d     = alu_wr || lsu_wr;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    rf_thread_d = rf_thread_q;
    done_d      = '0;
    if (alu_wr) begin
      rf_waddr_d  = alu_rd_addr;
      rf_wdata_d  = alu_rd_data;
      rf_thread_d = alu_thread;
    end else if (lsu_wr) begin
      rf_waddr_d  = fifo_head.rd_addr;
      rf_wdata_d  = fifo_head.data;
      rf_thread_d = fifo_head.thread;
    end
    if (alu_retire) done_d[alu_thread]       = 1'b1;
    if (fifo_pop)   done_d[fifo_head.thread] = 1'b1;
  end

  // Registered write port, retire pulses and LSU ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      rf_thread_q <= '0;
      done_q      <= '0;
      lsu_ready_q <= 1'b0;
    end else begin
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      rf_thread_q <= rf_thread_d;
      done_q      <= done_d;
      lsu_ready_q <= lsu_ready_d;
    end
  end

  // Per-thread PC table: every ALU result carries the thread's next PC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int t = 0; t < THREADS; t++) pc_tbl_q[t] <= '0;
    end else if (alu_valid) begin
      pc_tbl_q[alu_thread] <= alu_new_pc;
    end
  end

  for (genvar t = 0; t < THREADS; t++) begin : g_pc_out
    assign pc_q[t*PC_W +: PC_W] = pc_tbl_q[t];
  end

  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign rf_thread   = rf_thread_q;
  assign thread_done = done_q;
  assign lsu_ready   = lsu_ready_q;

`ifdef WB_PERF_EN
  logic [31:0] perf_alu_q;
  logic [31:0] perf_lsu_q;
  logic [31:0] perf_stall_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  // Event counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_alu_q   <= '0;
      perf_lsu_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (alu_wr)                    perf_alu_q   <= sat_inc(perf_alu_q);
      if (lsu_wr)                    perf_lsu_q   <= sat_inc(perf_lsu_q);
      if (lsu_valid && !lsu_ready_q) perf_stall_q <= sat_inc(perf_stall_q);
    end
  end

  assign perf_alu_wr    = perf_alu_q;
  assign perf_lsu_wr    = perf_lsu_q;
  assign perf_lsu_stall = perf_stall_q;
`else
  // Performance counters are compiled out of this build.
`endif

endmodule

// File: tb/tb_exu_writeback.sv
// tb_exu_writeback: directed stimulus with a scoreboard queue of expected
// writeback events, checked by an independent negedge monitor.
module tb_exu_writeback;

  localparam int XLEN = 32, THREADS = 4, PC_W = 29, LSU_DEPTH = 4, TID_W = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    alu_valid, alu_rd_en;
  logic [4:0]              alu_rd_addr;
  logic [XLEN-1:0]         alu_rd_data;
  logic [PC_W-1:0]         alu_new_pc;
  logic [TID_W-1:0]        alu_thread;
  logic                    lsu_valid, lsu_ready;
  logic [4:0]              lsu_rd_addr;
  logic [XLEN-1:0]         lsu_rd_data;
  logic [TID_W-1:0]        lsu_thread;
  logic                    rf_we;
  logic [4:0]              rf_waddr;
  logic [XLEN-1:0]         rf_wdata;
  logic [TID_W-1:0]        rf_thread;
  logic [THREADS*PC_W-1:0] pc_q;
  logic [THREADS-1:0]      thread_done;
`ifdef WB_PERF_EN
  logic [31:0]             perf_alu_wr, perf_lsu_wr, perf_lsu_stall;
`endif

  always #5 clk = ~clk;

  exu_writeback #(
    .XLEN(XLEN), .THREADS(THREADS), .PC_W(PC_W), .LSU_DEPTH(LSU_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd_en(alu_rd_en), .alu_rd_addr(alu_rd_addr),
    .alu_rd_data(alu_rd_data), .alu_new_pc(alu_new_pc), .alu_thread(alu_thread),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd_addr(lsu_rd_addr),
    .lsu_rd_data(lsu_rd_data), .lsu_thread(lsu_thread),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_thread(rf_thread),
    .pc_q(pc_q),
`ifdef WB_PERF_EN
    .perf_alu_wr(perf_alu_wr), .perf_lsu_wr(perf_lsu_wr), .perf_lsu_stall(perf_lsu_stall),
`endif
    .thread_done(thread_done)
  );

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [1:0]  thr;
    logic [3:0]  done;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   k      = 0;
  int   base   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void push_exp(input logic we, input logic [4:0] a, input logic [31:0] d,
                                   input logic [1:0] t, input logic [3:0] dn, input int c);
    exp_t e;
    e.we = we; e.addr = a; e.data = d; e.thr = t; e.done = dn; e.cyc = c;
    exp_q.push_back(e);
  endfunction

  // Monitor: every visible writeback event must match the head of the queue.
  always @(negedge clk) begin
    if (rst === 1'b1 && (rf_we !== 1'b0 || thread_done !== 4'b0)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wb: we=%0b addr=%0d data=%0h done=%b with nothing expected (cycle %0d)",
                 rf_we, rf_waddr, rf_wdata, thread_done, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_cycle", 64'(cyc), 64'(mon_e.cyc));
        chk("rf_we", 64'(rf_we), 64'(mon_e.we));
        if (mon_e.we) begin
          chk("rf_waddr", 64'(rf_waddr), 64'(mon_e.addr));
          chk("rf_wdata", 64'(rf_wdata), 64'(mon_e.data));
          chk("rf_thread", 64'(rf_thread), 64'(mon_e.thr));
        end
        chk("thread_done", 64'(thread_done), 64'(mon_e.done));
      end
    end
  end

  task automatic idle();
    alu_valid = 1'b0; alu_rd_en = 1'b0; alu_rd_addr = '0; alu_rd_data = '0;
    alu_new_pc = '0; alu_thread = '0;
    lsu_valid = 1'b0; lsu_rd_addr = '0; lsu_rd_data = '0; lsu_thread = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic en, input logic [4:0] rd, input logic [31:0] d,
                     input logic [28:0] pc, input logic [1:0] t);
    alu_valid = 1'b1; alu_rd_en = en; alu_rd_addr = rd; alu_rd_data = d;
    alu_new_pc = pc; alu_thread = t;
  endtask

  task automatic lsu(input logic [4:0] rd, input logic [31:0] d, input logic [1:0] t);
    lsu_valid = 1'b1; lsu_rd_addr = rd; lsu_rd_data = d; lsu_thread = t;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rf_we"}, 64'(rf_we), 64'd0);
    chk({tag, "_rf_waddr"}, 64'(rf_waddr), 64'd0);
    chk({tag, "_rf_wdata"}, 64'(rf_wdata), 64'd0);
    chk({tag, "_rf_thread"}, 64'(rf_thread), 64'd0);
    chk({tag, "_thread_done"}, 64'(thread_done), 64'd0);
    chk({tag, "_pc_hi"}, 64'(pc_q[THREADS*PC_W-1:64]), 64'd0);
    chk({tag, "_pc_lo"}, pc_q[63:0], 64'd0);
    chk({tag, "_lsu_ready"}, 64'(lsu_ready), 64'd0);
  endtask

  task automatic drain(input string tag);
    for (int w = 0; w < 20 && exp_q.size() != 0; w++) step();
    chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 chk_reset_outputs("por");
    step(); step();
    rst = 1'b1;
    step();
    chk("ready_after_release", 64'(lsu_ready), 64'd1);

    // Test 1: three loads queued behind ALU writes, then reset mid-stream.
    for (int i = 0; i < 3; i++) begin
      alu(1'b1, 5'(10 + i), 32'(100 + i), 29'd7, 2'd3);
      lsu(5'(20 + i), 32'(200 + i), 2'd0);
      if (i < 2) push_exp(1'b1, 5'(10 + i), 32'(100 + i), 2'd3, 4'b1000, cyc + 1);
      step();
    end
    rst = 1'b0;
    idle();
    #1 chk_reset_outputs("midrst");
    step();
    rst = 1'b1;
    step();
    chk("t1_ready_after_release", 64'(lsu_ready), 64'd1);
    for (int i = 0; i < 5; i++) step();
    chk("t1_no_stale", 64'(exp_q.size()), 64'd0);

    // Test 2: plain ALU write.
    alu(1'b1, 5'd5, 32'hDEADBEEF, 29'h40, 2'd2);
    push_exp(1'b1, 5'd5, 32'hDEADBEEF, 2'd2, 4'b0100, cyc + 1);
    step();
    idle();
    chk("t2_pc2", 64'(pc_q[2*PC_W +: PC_W]), 64'h40);
    step();

    // Test 3: ALU write to x0 is dropped but still retires and moves the PC.
    alu(1'b1, 5'd0, 32'h1234, 29'h55, 2'd1);
    push_exp(1'b0, 5'd0, 32'h0, 2'd1, 4'b0010, cyc + 1);
    step();
    idle();
    chk("t3_pc1", 64'(pc_q[1*PC_W +: PC_W]), 64'h55);
    step();

    // Test 4: ALU and LSU in the same cycle, ALU wins.
    alu(1'b1, 5'd3, 32'hA, 29'h60, 2'd1);
    lsu(5'd7, 32'hB, 2'd0);
    push_exp(1'b1, 5'd3, 32'hA, 2'd1, 4'b0010, cyc + 1);
    push_exp(1'b1, 5'd7, 32'hB, 2'd0, 4'b0001, cyc + 2);
    step();
    idle();
    drain("t4");

    // Test 6: load ALU slot gives no pulse; load retires at its own write.
    alu(1'b0, 5'd9, 32'h0, 29'h70, 2'd2);
    lsu(5'd9, 32'h99, 2'd2);
    push_exp(1'b1, 5'd9, 32'h99, 2'd2, 4'b0100, cyc + 2);
    step();
    idle();
    chk("t6_pc2", 64'(pc_q[2*PC_W +: PC_W]), 64'h70);
    lsu(5'd0, 32'h77, 2'd3);
    push_exp(1'b0, 5'd0, 32'h0, 2'd3, 4'b1000, cyc + 2);
    step();
    idle();
    drain("t6");

    // Fresh reset so the counters cover test 5 alone.
    rst = 1'b0;
    step();
    rst = 1'b1;
    step(); step();

    // Test 5: ALU busy 8 cycles while LSU offers 6 loads; only 4 fit.
    base = cyc;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      alu(1'b1, 5'(c + 1), 32'h1000 + 32'(c), 29'(c), 2'(c % 4));
      push_exp(1'b1, 5'(c + 1), 32'h1000 + 32'(c), 2'(c % 4), 4'(1 << (c % 4)), cyc + 1);
      chk("t5_lsu_ready", 64'(lsu_ready), 64'(c < 4));
      if (k < 6) lsu(5'(16 + k), 32'hC000_0000 + 32'(k), 2'(k % 4));
      if (lsu_ready) k++;
      step();
    end
    idle();
    for (int j = 0; j < 4; j++)
      push_exp(1'b1, 5'(16 + j), 32'hC000_0000 + 32'(j), 2'(j % 4), 4'(1 << (j % 4)), base + 9 + j);
    drain("t5");
`ifdef WB_PERF_EN
    chk("perf_alu_wr", 64'(perf_alu_wr), 64'd8);
    chk("perf_lsu_wr", 64'(perf_lsu_wr), 64'd4);
    chk("perf_lsu_stall", 64'(perf_lsu_stall), 64'd4);
`endif
    step(); step();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
